// File: rtl/hc595_driver_if.sv
// Host-side handshake for hc595_driver: byte/start/clear/enable requests and busy/done status.
interface hc595_driver_if;
  logic       start;
  logic [7:0] data;
  logic       clr;
  logic       oe;
  logic       busy;
  logic       done;

  modport master (output start, data, clr, oe, input busy, done);
  modport slave  (input start, data, clr, oe, output busy, done);
endinterface

// File: rtl/hc595_driver.sv
// Serialises a host byte into a 74HC595 (si/sck), latches it with rck, and
// drives the 595 clear (sclr_n) and output enable (g_n) pins. All outputs registered.
module hc595_driver #(
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  hc595_driver_if.slave  host,
  output logic           si,
  output logic           sck,
  output logic           rck,
  output logic           sclr_n,
  output logic           g_n
);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT_LO, SHIFT_HI, LATCH, FINISH} state_t;

  localparam int              CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             phase_end;

  assign phase_end = (cnt == CNT_LAST);

  function automatic logic [7:0] shift_next(input logic [7:0] v);
    return MSB_FIRST ? {v[6:0], 1'b0} : {1'b0, v[7:1]};
  endfunction

  function automatic logic out_bit(input logic [7:0] v);
    return MSB_FIRST ? v[7] : v[0];
  endfunction

  // Output enable is a plain one-cycle registered inversion, outside the FSM.
  always_ff @(posedge clk) begin
    if (rst) g_n <= 1'b1;
    else     g_n <= ~host.oe;
  end

  // shreg is pure datapath and is only meaningful after a capture, so it has no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      host.busy <= 1'b0;
      host.done <= 1'b0;
      si        <= 1'b0;
      sck       <= 1'b0;
      rck       <= 1'b0;
      sclr_n    <= 1'b0;
    end else begin
      host.done <= 1'b0;
      sclr_n    <= 1'b1;
      case (state)
        IDLE, FINISH: begin
          rck <= 1'b0;
          cnt <= '0;
          if (host.clr) begin
            state     <= CLEAR;
            host.busy <= 1'b1;
            sclr_n    <= 1'b0;
            sck       <= 1'b0;
            si        <= 1'b0;
          end else if (host.start) begin
            state     <= SHIFT_LO;
            host.busy <= 1'b1;
            shreg     <= host.data;
            bit_cnt   <= '0;
            sck       <= 1'b0;
            si        <= out_bit(host.data);
          end else begin
            state <= IDLE;
          end
        end
        CLEAR: begin
          if (phase_end) begin
            state <= LATCH;
            cnt   <= '0;
            rck   <= 1'b1;
          end else begin
            cnt    <= cnt + CNT_W'(1);
            sclr_n <= 1'b0;
          end
        end
        SHIFT_LO: begin
          if (phase_end) begin
            state <= SHIFT_HI;
            cnt   <= '0;
            sck   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHIFT_HI: begin
          if (phase_end) begin
            cnt     <= '0;
            sck     <= 1'b0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= LATCH;
              rck   <= 1'b1;
              si    <= 1'b0;
            end else begin
              state <= SHIFT_LO;
              shreg <= shift_next(shreg);
              si    <= out_bit(shift_next(shreg));
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LATCH: begin
          if (phase_end) begin
            state     <= FINISH;
            cnt       <= '0;
            rck       <= 1'b0;
            host.busy <= 1'b0;
            host.done <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hc595_driver.sv
// Directed bench for hc595_driver: two instances (DIV=1 MSB-first, DIV=4 LSB-first),
// each feeding a small behavioural 74HC595 model.
module tb_hc595_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hc595_driver_if h1 ();
  hc595_driver_if h4 ();

  logic si1, sck1, rck1, sclr1, g1;
  logic si4, sck4, rck4, sclr4, g4;

  hc595_driver #(.DIV(1), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .host(h1),
    .si(si1), .sck(sck1), .rck(rck1), .sclr_n(sclr1), .g_n(g1)
  );

  hc595_driver #(.DIV(4), .MSB_FIRST(1'b0)) dut4 (
    .clk(clk), .rst(rst), .host(h4),
    .si(si4), .sck(sck4), .rck(rck4), .sclr_n(sclr4), .g_n(g4)
  );

  // 74HC595 model: SI enters QA and moves toward QH; q = {qh..qa}.
  logic [7:0] sr1, q1, sr4, q4;
  always @(posedge sck1 or negedge sclr1)
    if (!sclr1) sr1 <= 8'h00; else sr1 <= {sr1[6:0], si1};
  always @(posedge rck1) q1 <= sr1;
  always @(posedge sck4 or negedge sclr4)
    if (!sclr4) sr4 <= 8'h00; else sr4 <= {sr4[6:0], si4};
  always @(posedge rck4) q4 <= sr4;

  int checks = 0;
  int errors = 0;

  task automatic test_reset();
    h1.start = 0; h1.clr = 0; h1.oe = 0; h1.data = 8'h00;
    h4.start = 0; h4.clr = 0; h4.oe = 0; h4.data = 8'h00;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++; if (sclr1 !== 1'b0) begin errors++; $display("FAIL reset_sclr_n: got %b want 0", sclr1); end
    checks++; if (g1 !== 1'b1) begin errors++; $display("FAIL reset_g_n: got %b want 1", g1); end
    checks++; if ({h1.busy, h1.done, si1, sck1, rck1} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got busy,done,si,sck,rck=%b want 00000", {h1.busy, h1.done, si1, sck1, rck1});
    end
    checks++; if ({sclr4, g4, h4.busy, sck4, rck4} !== 5'b01000) begin
      errors++; $display("FAIL reset_dut4: got sclr,g,busy,sck,rck=%b want 01000", {sclr4, g4, h4.busy, sck4, rck4});
    end
    rst = 0;
    @(negedge clk);
    checks++; if ({sclr1, sclr4} !== 2'b11) begin errors++; $display("FAIL reset_release_sclr_n: got %b want 11", {sclr1, sclr4}); end
    h1.oe = 1; h4.oe = 1;
    @(negedge clk);
  endtask

  task automatic test_msb_div1();
    logic [7:0] bits = 8'h00;
    logic prev = 1'b0;
    int rises = 0, rck_rises = 0, done_m = -1, dones = 0;
    logic prev_rck = 1'b0;
    h1.data = 8'hB5; h1.start = 1;
    for (int m = 0; m < 30; m++) begin
      @(negedge clk);
      if (m == 0) begin
        h1.start = 0; h1.data = 8'h00;
        checks++; if ({h1.busy, sck1, si1} !== 3'b101) begin
          errors++; $display("FAIL msb_first_cycle: got busy,sck,si=%b want 101", {h1.busy, sck1, si1});
        end
      end
      if (sck1 && !prev) begin rises++; bits = {bits[6:0], si1}; end
      if (rck1 && !prev_rck) rck_rises++;
      if (h1.done) begin dones++; if (done_m < 0) done_m = m; end
      prev = sck1; prev_rck = rck1;
    end
    checks++; if (bits !== 8'hB5) begin errors++; $display("FAIL msb_si_sequence: got %h want b5", bits); end
    checks++; if (rises != 8) begin errors++; $display("FAIL msb_sck_pulses: got %0d want 8", rises); end
    checks++; if (rck_rises != 1) begin errors++; $display("FAIL msb_rck_pulses: got %0d want 1", rck_rises); end
    checks++; if (done_m != 17 || dones != 1) begin
      errors++; $display("FAIL msb_done_timing: got cycle %0d count %0d want 17 and 1", done_m, dones);
    end
    checks++; if (q1 !== 8'hB5) begin errors++; $display("FAIL msb_595_outputs: got %h want b5", q1); end
    checks++; if (g1 !== 1'b0) begin errors++; $display("FAIL msb_g_n: got %b want 0", g1); end
  endtask

  task automatic test_lsb_div4();
    logic [7:0] bits = 8'h00;
    logic prev = 1'b0;
    int rises = 0, bad_pos = 0, si_high = 0, done_m = -1;
    h4.data = 8'h01; h4.start = 1;
    for (int m = 0; m < 90; m++) begin
      @(negedge clk);
      if (m == 0) begin
        h4.start = 0;
        checks++; if (si4 !== 1'b1) begin errors++; $display("FAIL lsb_first_bit: got %b want 1", si4); end
      end
      if (si4) si_high++;
      if (sck4 && !prev) begin
        if (m != 4 + 8 * rises) bad_pos++;
        rises++; bits = {bits[6:0], si4};
      end
      if (h4.done && done_m < 0) done_m = m;
      prev = sck4;
    end
    checks++; if (bits !== 8'h80) begin errors++; $display("FAIL lsb_si_sequence: got %h want 80", bits); end
    checks++; if (rises != 8 || bad_pos != 0) begin
      errors++; $display("FAIL lsb_sck_phases: got %0d rises, %0d misplaced want 8 and 0", rises, bad_pos);
    end
    checks++; if (si_high != 8) begin errors++; $display("FAIL lsb_si_high_cycles: got %0d want 8", si_high); end
    checks++; if (done_m != 68) begin errors++; $display("FAIL lsb_done_timing: got %0d want 68", done_m); end
    checks++; if (q4 !== 8'h80) begin errors++; $display("FAIL lsb_595_outputs: got %h want 80", q4); end
  endtask

  task automatic test_clear();
    int low = 0, low_first = -1, rck_m = -1, done_m = -1, rises = 0;
    logic prev = 1'b0;
    h1.clr = 1;
    for (int m = 0; m < 10; m++) begin
      @(negedge clk);
      if (m == 0) h1.clr = 0;
      if (!sclr1) begin low++; if (low_first < 0) low_first = m; end
      if (rck1 && rck_m < 0) rck_m = m;
      if (sck1 && !prev) rises++;
      if (h1.done && done_m < 0) done_m = m;
      prev = sck1;
    end
    checks++; if (low != 1 || low_first != 0) begin
      errors++; $display("FAIL clear_sclr_n: got %0d low cycles from %0d want 1 from 0", low, low_first);
    end
    checks++; if (rck_m != 1) begin errors++; $display("FAIL clear_rck: got cycle %0d want 1", rck_m); end
    checks++; if (done_m != 2) begin errors++; $display("FAIL clear_done: got cycle %0d want 2", done_m); end
    checks++; if (rises != 0) begin errors++; $display("FAIL clear_sck_edges: got %0d want 0", rises); end
    checks++; if (q1 !== 8'h00) begin errors++; $display("FAIL clear_595_outputs: got %h want 00", q1); end
  endtask

  task automatic test_priority();
    int rises = 0, done_m = -1;
    logic prev = 1'b0;
    h1.data = 8'hB5; h1.clr = 1; h1.start = 1;
    for (int m = 0; m < 10; m++) begin
      @(negedge clk);
      if (m == 0) begin h1.clr = 0; h1.start = 0; end
      if (sck1 && !prev) rises++;
      if (h1.done && done_m < 0) done_m = m;
      prev = sck1;
    end
    checks++; if (rises != 0 || done_m != 2) begin
      errors++; $display("FAIL priority_clear_wins: got %0d sck rises, done at %0d want 0 and 2", rises, done_m);
    end
    checks++; if (q1 !== 8'h00) begin errors++; $display("FAIL priority_595_outputs: got %h want 00", q1); end
  endtask

  task automatic test_back_to_back();
    int done1 = -1, done2 = -1;
    h1.data = 8'h3C; h1.start = 1;
    for (int m = 0; m < 40; m++) begin
      @(negedge clk);
      if (m == 0) h1.start = 0;
      if (m == 3) begin h1.start = 1; h1.data = 8'hFF; end
      if (m == 6) h1.start = 0;
      if (m == 18) begin
        h1.start = 0;
        checks++; if ({h1.busy, sck1, si1} !== 3'b101) begin
          errors++; $display("FAIL b2b_second_start: got busy,sck,si=%b want 101", {h1.busy, sck1, si1});
        end
      end
      if (h1.done) begin if (done1 < 0) done1 = m; else if (done2 < 0) done2 = m; end
      if (m == 17) begin
        checks++; if (q1 !== 8'h3C) begin errors++; $display("FAIL ignore_busy_start: got %h want 3c", q1); end
        h1.data = 8'hA7; h1.start = 1;
      end
    end
    checks++; if (done1 != 17 || done2 != 35) begin
      errors++; $display("FAIL b2b_done_timing: got %0d,%0d want 17,35", done1, done2);
    end
    checks++; if (q1 !== 8'hA7) begin errors++; $display("FAIL b2b_595_outputs: got %h want a7", q1); end
  endtask

  task automatic test_reset_mid();
    int rises = 0, dones = 0;
    logic prev = 1'b0;
    logic hit = 1'b0;
    h1.data = 8'h5A; h1.start = 1;
    for (int m = 0; m < 20 && !hit; m++) begin
      @(negedge clk);
      if (m == 0) h1.start = 0;
      if (sck1 && !prev) rises++;
      prev = sck1;
      if (rises == 3) begin hit = 1'b1; rst = 1; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL midreset_third_edge: got %0d rises want 3", rises); end
    @(negedge clk);
    checks++; if ({sck1, rck1, h1.busy, h1.done} !== 4'b0) begin
      errors++; $display("FAIL midreset_outputs: got sck,rck,busy,done=%b want 0000", {sck1, rck1, h1.busy, h1.done});
    end
    rst = 0;
    for (int m = 0; m < 25; m++) begin
      @(negedge clk);
      if (h1.done) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL midreset_no_done: got %0d want 0", dones); end
    checks++; if (q1 !== 8'hA7) begin errors++; $display("FAIL midreset_595_outputs: got %h want a7", q1); end
  endtask

  initial begin
    test_reset();
    test_msb_div1();
    test_lsb_div4();
    test_clear();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hc595_driver.md
# hc595_driver

Parallel-to-serial front end that drives an external or modelled 74HC595 shift/storage register. A host presents one byte with a start strobe. The block serialises the byte onto `si` with a generated `sck`, then pulses `rck` to latch the byte into the 595 outputs. It also produces `sclr_n` (clear) and `g_n` (output enable). It sits directly upstream of `hc595`, and its outputs connect one-to-one to that block's `si`, `sck`, `rck`, `sclr_n` and `g_n` inputs.

## Interface
- `DIV`, default 4: length of every serial phase in `clk` cycles, ≥1. `sck` period is 2·DIV.
- `MSB_FIRST`, default 1: 1 shifts `data[7]` first, so it ends in QH and `data[0]` ends in QA. 0 shifts `data[0]` first.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to transmit `data`; sampled only when `busy`=0.
- `data`  in  8  byte to transmit; captured on the accepted `start`.
- `clr`  in  1  request to clear the 595 shift and storage registers; sampled only when `busy`=0.
- `oe`  in  1  output enable request, active high.
- `busy`  out  1  transfer or clear in progress.
- `done`  out  1  one-cycle pulse when a transfer or clear completes.
- `si`  out  1  serial data to the 595.
- `sck`  out  1  595 shift clock; data is shifted on its rising edge.
- `rck`  out  1  595 storage clock; data is latched on its rising edge.
- `sclr_n`  out  1  595 shift-register clear, active low.
- `g_n`  out  1  595 output enable, active low.

## Operation
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `si`=0, `sck`=0, `rck`=0, `g_n`=1, `sclr_n`=0 while `rst`=1. `sclr_n` returns to 1 in the first cycle after reset is released. The FSM goes to IDLE.
- `g_n` = ~`oe`, delayed one cycle, and is independent of the FSM.
- FSM states: IDLE, CLEAR, SHIFT_LO, SHIFT_HI, LATCH, FINISH.
- IDLE:
  - If `clr`=1, go to CLEAR. `clr` wins over a simultaneous `start`.
  - Else if `start`=1, capture `data` into the shift register, set the bit counter to 0, and go to SHIFT_LO.
- SHIFT_LO (DIV cycles): `sck`=0 and `si` = current bit. `si` is valid from the first cycle of the state.
- SHIFT_HI (DIV cycles): `sck`=1 and `si` is held. On exit:
  - the counter increments;
  - if the counter was 7, go to LATCH;
  - otherwise go to SHIFT_LO with the next bit.
- CLEAR (DIV cycles): `sclr_n`=0 and `sck`=0, then go to LATCH. Latching after the clear propagates zeros to QA..QH.
- LATCH (DIV cycles): `rck`=1, `sck`=0, `si`=0, then go to FINISH.
- FINISH (1 cycle): `rck`=0, `busy`=0, `done`=1, then go to IDLE. A new `start` or `clr` is accepted in this cycle, and the FSM goes directly to SHIFT_LO or CLEAR.
- `start` and `clr` are ignored while `busy`=1; `data` changes during a transfer have no effect.
- If `rst` is asserted mid-transfer, the next edge forces the reset values. `sck`/`rck` drop to 0 with no partial latch, and the transfer is abandoned with no `done`.

## Timing
- `start` is accepted at edge T0. From T0+1:
  - `busy`=1, `sck`=0, `si`=bit0;
  - the first `sck` rising edge is at T0+1+DIV.
- Bit k: `sck` rises at T0+1+DIV·(2k+1).
- `rck` rises at T0+1+16·DIV and falls at T0+1+17·DIV.
- `done`=1 and `busy`=0 during the cycle beginning T0+1+17·DIV. A transfer therefore occupies 17·DIV busy cycles.
- Clear accepted at T0: `sclr_n`=0 over [T0+1, T0+1+DIV), `rck` high for the next DIV cycles, `done` at T0+1+2·DIV.
- Setup to the 595: `si` is stable for DIV cycles before and DIV cycles after each `sck` rising edge. `sclr_n` is high and `sck` is low when `rck` rises.
- Back-to-back transfers have `sck` idle (low) for LATCH+FINISH, i.e. DIV+1 cycles.

## Test plan
- Reset: hold `rst` 3 cycles, then release. Required: `sclr_n`=0 during reset and 1 one cycle after release; `g_n`=1; `busy`=`done`=`si`=`sck`=`rck`=0.
- Byte transfer: DIV=1, MSB_FIRST=1, `data`=8'hB5, `start` pulse, `hc595` attached, `oe`=1. Required:
  - `si` sequence 1,0,1,1,0,1,0,1 at the `sck` rising edges;
  - 8 `sck` pulses and one `rck` pulse;
  - `done` exactly 17 cycles after acceptance;
  - {qh..qa} = 8'hB5;
  - `g_n`=0.
- LSB-first with DIV=4: MSB_FIRST=0, `data`=8'h01. Required: `si`=1 only during the first bit; `sck` high and low phases of 4 cycles; `done` at +68 cycles; qh=1 and all other outputs 0.
- Clear: after the 8'hB5 load, `clr` pulse. Required: `sclr_n` low DIV cycles, then an `rck` pulse, then `done`; qa..qh all 0; no `sck` edges.
- Priority, ignore and back-to-back:
  - `clr` and `start` together → clear only.
  - `start` with new data during `busy` → ignored; the first byte's output is unchanged.
  - `start` in the FINISH cycle → accepted; the second transfer begins the next cycle.
- Reset mid-transfer: assert `rst` after the 3rd `sck` rising edge. Required: `sck`/`rck` go 0 the next cycle; no `done`; 595 storage outputs unchanged from their prior value.
